// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command handshake and status bundle for shift_sequencer.
//   cmd_valid/cmd_ready : command handshake (accept = both high at a falling clk edge)
//   cmd_op              : 00 LOAD, 01 SHL, 10 SHR, 11 ROL
//   cmd_data            : parallel value for LOAD
//   cmd_count           : step count for SHL/SHR/ROL
//   ser_in              : serial fill bit, sampled at every step edge
//   q                   : shift register contents
//   busy / done         : status (RUN state / one-cycle completion pulse)
// master modport is the requester; slave modport is the sequencer.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, ser_in,
        input  cmd_ready, q, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, ser_in,
        output cmd_ready, q, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for a WIDTH-bit shift register.
// Accepts LOAD / SHL / SHR / ROL commands one at a time and pulses done for
// one cycle on completion. All state changes on the falling edge of clk.
// Ports:
//   clk   : clock (falling-edge active)
//   reset : asynchronous active-high reset
//   bus   : shift_sequencer_if slave modport (handshake, operands, q, status)
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic               clk,
    input logic               reset,
    shift_sequencer_if.slave  bus
);
    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpShl  = 2'b01;
    localparam logic [1:0] OpShr  = 2'b10;
    localparam logic [1:0] OpRol  = 2'b11;

    // One-hot so that each status output is a single flop (glitch-free).
    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StRun  = 3'b010,
        StDone = 3'b100
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;

    state_e           w_state_next;
    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_op_next;
    logic [WIDTH-1:0] w_step;

    // Single step of the latched operation; ser_in is taken live.
    always_comb begin
        w_step = r_q;
        case (r_op)
            OpShl:   w_step = {r_q[WIDTH-2:0], bus.ser_in};
            OpShr:   w_step = {bus.ser_in, r_q[WIDTH-1:1]};
            OpRol:   w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            default: w_step = r_q;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OpLoad) begin
                        w_q_next     = bus.cmd_data;
                        w_state_next = StDone;
                    end else begin
                        w_op_next  = bus.cmd_op;
                        w_cnt_next = bus.cmd_count;
                        w_state_next = (bus.cmd_count == '0) ? StDone : StRun;
                    end
                end
            end
            StRun: begin
                w_q_next   = w_step;
                w_cnt_next = r_cnt - CNT_W'(1);
                // The edge applying the last step also leaves RUN.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= OpLoad;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
        end
    end

    assign bus.cmd_ready = r_state[0];
    assign bus.busy      = r_state[1];
    assign bus.done      = r_state[2];
    assign bus.q         = r_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.
// Active edge is the falling clk edge; outputs are sampled 1 ns after it.
module tb_shift_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpShl  = 2'b01;
    localparam logic [1:0] OpShr  = 2'b10;
    localparam logic [1:0] OpRol  = 2'b11;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a command for exactly one active edge, then drop valid.
    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_data  = data;
        bif.cmd_count = cnt;
        tick();
        bif.cmd_valid = 1'b0;
    endtask

    task automatic status(input string tag, input logic rdy, input logic bsy, input logic dn);
        check({tag, ".ready"}, 32'(bif.cmd_ready), 32'(rdy));
        check({tag, ".busy"},  32'(bif.busy),      32'(bsy));
        check({tag, ".done"},  32'(bif.done),      32'(dn));
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = OpLoad;
        bif.cmd_data  = 8'h00;
        bif.cmd_count = 4'd0;
        bif.ser_in    = 1'b0;

        // Reset state, released away from a falling edge.
        #12;
        check("rst.q", 32'(bif.q), 32'h00);
        status("rst", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // Thermometer fill: SHL 8 with ser_in = 1.
        bif.ser_in = 1'b1;
        issue(OpShl, 8'h00, 4'd8);
        check("therm.accept.q", 32'(bif.q), 32'h00);
        status("therm.accept", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("therm.q%0d", i), 32'(bif.q), (32'd1 << i) - 32'd1);
            if (i < 8) check($sformatf("therm.busy%0d", i), 32'(bif.busy), 32'd1);
        end
        status("therm.done", 1'b0, 1'b0, 1'b1);
        tick();
        status("therm.idle", 1'b1, 1'b0, 1'b0);
        check("therm.hold", 32'(bif.q), 32'hFF);

        // LOAD 0x81 then ROL 3 -> 0x0C.
        issue(OpLoad, 8'h81, 4'd0);
        check("load81.q", 32'(bif.q), 32'h81);
        status("load81", 1'b0, 1'b0, 1'b1);
        tick();
        issue(OpRol, 8'hFF, 4'd3);
        for (int i = 0; i < 3; i++) tick();
        check("rol3.q", 32'(bif.q), 32'h0C);
        status("rol3", 1'b0, 1'b0, 1'b1);
        tick();

        // ROL 8 restores 0xA5.
        issue(OpLoad, 8'hA5, 4'd0);
        tick();
        issue(OpRol, 8'h00, 4'd8);
        for (int i = 0; i < 8; i++) tick();
        check("rol8.q", 32'(bif.q), 32'hA5);
        check("rol8.done", 32'(bif.done), 32'd1);
        tick();

        // SHR 4 with ser_in = 0 from 0xF0; valid toggled with a LOAD during RUN.
        issue(OpLoad, 8'hF0, 4'd0);
        tick();
        bif.ser_in = 1'b0;
        issue(OpShr, 8'h00, 4'd4);
        check("shr.busy_rise", 32'(bif.busy), 32'd1);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = OpLoad;
        bif.cmd_data  = 8'hFF;
        bif.cmd_count = 4'd1;
        tick();
        check("shr.q1", 32'(bif.q), 32'h78);
        bif.cmd_valid = 1'b0;
        tick();
        check("shr.q2", 32'(bif.q), 32'h3C);
        bif.cmd_valid = 1'b1;
        tick();
        check("shr.q3", 32'(bif.q), 32'h1E);
        check("shr.busy3", 32'(bif.busy), 32'd1);
        bif.cmd_valid = 1'b0;
        tick();
        check("shr.q4", 32'(bif.q), 32'h0F);
        status("shr.done", 1'b0, 1'b0, 1'b1);
        tick();
        check("shr.idle.q", 32'(bif.q), 32'h0F);

        // Zero count: done on the cycle after accept, q unchanged.
        bif.ser_in = 1'b1;
        issue(OpShl, 8'h00, 4'd0);
        check("zero.q", 32'(bif.q), 32'h0F);
        status("zero", 1'b0, 1'b0, 1'b1);
        tick();
        status("zero.idle", 1'b1, 1'b0, 1'b0);

        // Reset mid-RUN: LOAD 0x55, SHL 6 (ser_in 0), reset after 2 steps.
        issue(OpLoad, 8'h55, 4'd0);
        tick();
        bif.ser_in = 1'b0;
        issue(OpShl, 8'h00, 4'd6);
        tick();
        tick();
        check("abort.q2", 32'(bif.q), 32'h54);
        #2 reset = 1'b1;
        #1;
        check("abort.q", 32'(bif.q), 32'h00);
        status("abort", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        status("abort.after", 1'b1, 1'b0, 1'b0);
        issue(OpLoad, 8'h3C, 4'd0);
        check("reload.q", 32'(bif.q), 32'h3C);
        check("reload.done", 32'(bif.done), 32'd1);
        tick();

        // Reset during DONE cuts the pulse immediately.
        issue(OpLoad, 8'h77, 4'd0);
        check("cut.pre", 32'(bif.done), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("cut.q", 32'(bif.q), 32'h00);
        status("cut", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // Back-to-back: valid held, LOAD 0x12 then ROL 1 -> 0x24, two done pulses.
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = OpLoad;
        bif.cmd_data  = 8'h12;
        bif.cmd_count = 4'd0;
        tick();
        check("b2b.q1", 32'(bif.q), 32'h12);
        status("b2b.done1", 1'b0, 1'b0, 1'b1);
        bif.cmd_op    = OpRol;
        bif.cmd_count = 4'd1;
        tick();
        status("b2b.idle", 1'b1, 1'b0, 1'b0);
        tick();
        status("b2b.run", 1'b0, 1'b1, 1'b0);
        bif.cmd_valid = 1'b0;
        tick();
        check("b2b.q2", 32'(bif.q), 32'h24);
        status("b2b.done2", 1'b0, 1'b0, 1'b1);
        tick();
        status("b2b.end", 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller that owns and sequences an 8-bit shift register of the LAB02 style. It accepts one command at a time over a valid/ready handshake: parallel load, shift left, shift right, or rotate left by a programmed step count. It signals completion with a one-cycle `done` pulse. It replaces free-running shifting: the register moves only while a command is executing.

## Interface

Parameters:
- `WIDTH`, default 8: shift register width in bits.
- `CNT_W`, default 4: width of the step count field (0–15 steps).

Ports:
- `clk`, input, 1 bit: the single clock. All state updates occur on the falling edge of `clk`.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `cmd_valid`, input, 1 bit: a command is presented.
- `cmd_ready`, output, 1 bit: the block can accept a command. High only in IDLE.
- `cmd_op`, input, 2 bits: operation select.
  - 00: LOAD
  - 01: SHL
  - 10: SHR
  - 11: ROL
- `cmd_data`, input, `WIDTH` bits: parallel value for LOAD; ignored for other ops.
- `cmd_count`, input, `CNT_W` bits: number of steps for SHL/SHR/ROL; ignored for LOAD.
- `ser_in`, input, 1 bit: serial fill bit for SHL (enters at bit 0) and SHR (enters at bit `WIDTH-1`).
- `q`, output, `WIDTH` bits: register contents, driven directly from flops.
- `busy`, output, 1 bit: high in RUN.
- `done`, output, 1 bit: high for exactly one cycle, in DONE.

## Operation

- States: IDLE, RUN, DONE. Encoding is free; outputs must be glitch-free (registered or decoded from state flops).
- Accept condition: `cmd_valid && cmd_ready` sampled at a falling edge. `cmd_op` and `cmd_count` are latched on that edge.
- IDLE transitions on accept:
  - LOAD: `q <= cmd_data` on the accept edge, then go to DONE.
  - SHL/SHR/ROL with `cmd_count == 0`: `q` unchanged, go to DONE.
  - SHL/SHR/ROL with `cmd_count == N > 0`: go to RUN with remaining count = N; `q` unchanged on the accept edge.
- RUN: each falling edge applies one step and decrements the remaining count. The edge that applies the last step moves the state to DONE.
- Step definitions:
  - SHL: `q <= {q[WIDTH-2:0], ser_in}`
  - SHR: `q <= {ser_in, q[WIDTH-1:1]}`
  - ROL: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`
- `ser_in` is sampled live at every step edge, not latched at accept.
- DONE: always returns to IDLE on the next edge; `q` holds.
- `cmd_valid` outside IDLE is ignored. Commands are not queued; the requester must hold `cmd_valid` until it sees `cmd_ready`.
- Counts ≥ `WIDTH` are legal:
  - SHL/SHR by ≥ `WIDTH` fully replaces `q` with sampled `ser_in` bits.
  - ROL by `WIDTH` restores the original value.
- `q` never changes in IDLE or DONE except via LOAD.

## Timing

- Reset (async, immediate on rising `reset`): state = IDLE, `q` = 0, remaining count = 0, `cmd_ready` = 1, `busy` = 0, `done` = 0.
- Release of `reset` is synchronized by the design's reset scheme. The first accept can occur at the first falling edge after release.
- Latency, with the accept at edge k:
  - Shift by N > 0: steps at edges k+1 … k+N; `done` high between edges k+N and k+N+1; `cmd_ready` high after edge k+N+1. A new command can be accepted at edge k+N+1... no earlier than the edge after that, i.e. one command per N+2 edges.
  - LOAD and count 0: `done` high between edges k and k+1; `cmd_ready` high after edge k+1. One command per 2 edges.
- `busy` and `cmd_ready` are never both high. `done` and `cmd_ready` are never both high.
- Reset mid-RUN: the operation aborts with no `done` pulse; `q` = 0 and the block is in IDLE.
- Reset during DONE: the `done` pulse is cut immediately.

## Test plan

- Thermometer fill: after reset, SHL with N=8 and `ser_in` held at 1 → `q` steps through 0x01, 0x03, 0x07, …, 0xFF on successive edges. `busy` is high for 8 cycles, then `done` is high for 1 cycle.
- LOAD then ROL: LOAD 0x81, then ROL with N=3 → `q` = 0x0C. ROL with N=8 from 0xA5 → 0xA5.
- SHR fill: LOAD 0xF0, then SHR with N=4 and `ser_in` = 0 → `q` = 0x0F. `done` is high exactly 4 cycles after the cycle in which `busy` rose.
- Zero count and ignored commands:
  - SHL with N=0 → `q` unchanged; `done` is high on the cycle after accept.
  - `cmd_valid` toggled during RUN → no effect on `q` or the step count.
- Reset mid-operation: LOAD 0x55, start SHL with N=6, assert `reset` after 2 steps → `q` = 0 immediately, no `done`, `cmd_ready` = 1. A following LOAD 0x3C completes normally.
- Back-to-back: `cmd_valid` held high with LOAD 0x12 followed by ROL with N=1 → the second command is accepted on the first edge `cmd_ready` is high. Final `q` = 0x24; there are two separate `done` pulses.
